fetch_stage: RTL and testbench

- Stage 1 of the 3-stage RV32I pipeline. Owns the PC and fetches from a variable-latency instruction memory.
- Fills the IF/ID register that the decode/execute stage consumes.
- Inserts the package NOP (32'h00000013) as the bubble on flush, on empty slots and at reset.
- Handles downstream stall and branch redirect from execute. At most one memory request is outstanding at any time.

---
 rtl/fetch_stage.sv | 148 ++++++++++++++
 tb/tb_fetch_stage.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Fetch stage of the 3-stage RV32I pipeline: owns the PC, keeps one request in
// flight to a variable-latency instruction memory and fills the IF/ID register.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] if_instr_o,
  output logic [31:0] if_pc_o,
  output logic        if_valid_o
);

  localparam logic [31:0] NOP          = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_ALN = {RESET_PC[31:2], 2'b00};

  localparam logic [1:0] S_REQ   = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [1:0]  state_p0, state_nxt;
  logic [31:0] pc_p0, pc_nxt;
  logic        hold_vld_p0, hold_vld_nxt;
  logic [31:0] hold_instr_p0, hold_pc_p0;
  logic        hold_load;
  logic        deliver;
  logic [31:0] deliver_instr, deliver_pc;
  logic [31:0] redirect_tgt;
  logic [31:0] pc_inc;

  logic [31:0] if_instr_p1, if_pc_p1;
  logic        vld_p1;

  assign redirect_tgt = {redirect_pc_i[31:2], 2'b00};
  assign pc_inc       = pc_p0 + 32'd4;
  assign imem_req     = (state_p0 == S_REQ);
  assign imem_addr    = pc_p0;

  always_comb begin
    state_nxt     = state_p0;
    pc_nxt        = pc_p0;
    hold_vld_nxt  = hold_vld_p0;
    hold_load     = 1'b0;
    deliver       = 1'b0;
    deliver_instr = imem_rdata;
    deliver_pc    = pc_p0;
    case (state_p0)
      S_REQ: begin
        // A redirect here cannot cancel the request already issued, so drain it.
        if (redirect_i) begin
          pc_nxt    = redirect_tgt;
          state_nxt = S_DRAIN;
        end else begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect_i) begin
          pc_nxt    = redirect_tgt;
          state_nxt = imem_valid ? S_REQ : S_DRAIN;
        end else if (imem_valid) begin
          if (stall_i) begin
            hold_load    = 1'b1;
            hold_vld_nxt = 1'b1;
            state_nxt    = S_HOLD;
          end else begin
            deliver   = 1'b1;
            pc_nxt    = pc_inc;
            state_nxt = S_REQ;
          end
        end
      end
      S_HOLD: begin
        if (redirect_i) begin
          hold_vld_nxt = 1'b0;
          pc_nxt       = redirect_tgt;
          state_nxt    = S_REQ;
        end else if (!stall_i) begin
          deliver       = 1'b1;
          deliver_instr = hold_instr_p0;
          deliver_pc    = hold_pc_p0;
          hold_vld_nxt  = 1'b0;
          pc_nxt        = pc_inc;
          state_nxt     = S_REQ;
        end
      end
      S_DRAIN: begin
        if (redirect_i) pc_nxt = redirect_tgt;
        if (imem_valid) state_nxt = S_REQ;
      end
      default: state_nxt = S_REQ;
    endcase
  end

  // Stage p0: fetch control, PC and hold buffer
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p0    <= S_REQ;
      pc_p0       <= RESET_PC_ALN;
      hold_vld_p0 <= 1'b0;
    end else begin
      state_p0    <= state_nxt;
      pc_p0       <= pc_nxt;
      hold_vld_p0 <= hold_vld_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (hold_load) begin
      hold_instr_p0 <= imem_rdata;
      hold_pc_p0    <= pc_p0;
    end
  end

  // Stage p1: IF/ID register; redirect flushes even under stall
  always_ff @(posedge clk) begin
    if (rst) begin
      if_instr_p1 <= NOP;
      if_pc_p1    <= 32'd0;
      vld_p1      <= 1'b0;
    end else if (redirect_i) begin
      if_instr_p1 <= NOP;
      if_pc_p1    <= 32'd0;
      vld_p1      <= 1'b0;
    end else if (!stall_i) begin
      if (deliver) begin
        if_instr_p1 <= deliver_instr;
        if_pc_p1    <= deliver_pc;
        vld_p1      <= 1'b1;
      end else begin
        if_instr_p1 <= NOP;
        vld_p1      <= 1'b0;
      end
    end
  end

  assign if_instr_o = if_instr_p1;
  assign if_pc_o    = if_pc_p1;
  assign if_valid_o = vld_p1;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus randomized traffic compared
// every cycle against a transaction-level model of the fetch rules.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, imem_req, imem_valid, stall_i, redirect_i, if_valid_o;
  logic [31:0] imem_addr, imem_rdata, redirect_pc_i, if_instr_o, if_pc_o;

  fetch_stage #(.RESET_PC(32'h0000_0000)) u_dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata), .stall_i(stall_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .if_instr_o(if_instr_o), .if_pc_o(if_pc_o), .if_valid_o(if_valid_o)
  );

  logic        w_rst, w_req, w_valid, w_ivld;
  logic [31:0] w_addr, w_rdata, w_instr, w_pc;

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst(w_rst), .imem_req(w_req), .imem_addr(w_addr),
    .imem_valid(w_valid), .imem_rdata(w_rdata), .stall_i(1'b0),
    .redirect_i(1'b0), .redirect_pc_i(32'h0),
    .if_instr_o(w_instr), .if_pc_o(w_pc), .if_valid_o(w_ivld)
  );

  int n_chk  = 0;
  int n_pass = 0;
  bit wrap_done = 1'b0;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
  endtask

  // Model: next fetch address, whether a request is in flight (and whether its
  // answer is unwanted), an optional parked instruction, and the IF/ID slot.
  logic [31:0] m_pc, m_buf_i, m_buf_p, m_if_i, m_if_p;
  bit          m_out, m_stale, m_buf, m_if_v;

  // Memory: at most one pending answer, delivered after a random latency.
  bit          mem_busy;
  int          mem_left, lat_min, lat_max;
  logic [31:0] mem_data, mem_salt;

  task automatic m_reset();
    m_pc = 32'h0; m_out = 1'b0; m_stale = 1'b0; m_buf = 1'b0;
    m_buf_i = 32'h0; m_buf_p = 32'h0;
    m_if_i = NOP; m_if_p = 32'h0; m_if_v = 1'b0;
  endtask

  // Called at a falling edge: check outputs, drive one cycle of inputs,
  // advance model and memory, then move to the next falling edge.
  task automatic step(input bit r, input bit s, input bit rd, input logic [31:0] tgt);
    bit          m_req, dlv, busy_now;
    logic [31:0] d_i, d_p, t;
    m_req = !m_out && !m_buf;
    chk1("imem_req", imem_req, m_req);
    if (m_req) chk32("imem_addr", imem_addr, m_pc);
    chk1("if_valid", if_valid_o, m_if_v);
    chk32("if_instr", if_instr_o, m_if_i);
    chk32("if_pc", if_pc_o, m_if_p);

    busy_now   = mem_busy;
    imem_valid = 1'b0;
    imem_rdata = $urandom;
    if (!r && mem_busy && mem_left == 1) begin
      imem_valid = 1'b1;
      imem_rdata = mem_data;
    end
    rst = r; stall_i = s; redirect_i = rd; redirect_pc_i = tgt;
    t = {tgt[31:2], 2'b00};

    dlv = 1'b0; d_i = 32'h0; d_p = 32'h0;
    if (r) begin
      m_reset();
    end else begin
      if (m_req) begin
        m_out = 1'b1;
        m_stale = rd;
        if (rd) m_pc = t;
      end else if (m_buf) begin
        if (rd) begin
          m_buf = 1'b0; m_pc = t;
        end else if (!s) begin
          dlv = 1'b1; d_i = m_buf_i; d_p = m_buf_p; m_buf = 1'b0; m_pc = m_pc + 32'd4;
        end
      end else if (imem_valid) begin
        m_out = 1'b0;
        if (m_stale || rd) begin
          m_stale = 1'b0;
          if (rd) m_pc = t;
        end else if (s) begin
          m_buf = 1'b1; m_buf_i = imem_rdata; m_buf_p = m_pc;
        end else begin
          dlv = 1'b1; d_i = imem_rdata; d_p = m_pc; m_pc = m_pc + 32'd4;
        end
      end else if (rd) begin
        m_pc = t; m_stale = 1'b1;
      end
      if (rd) begin
        m_if_i = NOP; m_if_v = 1'b0; m_if_p = 32'h0;
      end else if (!s) begin
        if (dlv) begin
          m_if_i = d_i; m_if_p = d_p; m_if_v = 1'b1;
        end else begin
          m_if_i = NOP; m_if_v = 1'b0;
        end
      end
    end

    if (r) begin
      mem_busy = 1'b0;
    end else begin
      if (imem_valid) mem_busy = 1'b0;
      else if (mem_busy) mem_left--;
      if (imem_req) begin
        chk1("req_while_outstanding", busy_now, 1'b0);
        mem_busy = 1'b1;
        mem_left = $urandom_range(lat_max, lat_min);
        mem_data = imem_addr ^ mem_salt;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0;
    imem_valid = 1'b0; imem_rdata = 32'h0;
    mem_busy = 1'b0; mem_left = 0; mem_data = 32'h0; mem_salt = 32'h0;
    lat_min = 1; lat_max = 1;
    m_reset();
    @(negedge clk);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk1("rst_req", imem_req, 1'b1);
    chk32("rst_addr", imem_addr, 32'h0);
    chk1("rst_vld", if_valid_o, 1'b0);
    chk32("rst_instr", if_instr_o, NOP);
    chk32("rst_pc", if_pc_o, 32'h0);

    // Latency 1, data = address: one instruction every two cycles
    for (int k = 0; k < 2; k++) begin
      step(1'b0, 1'b0, 1'b0, 32'h0);
      chk1("seq_wait_req", imem_req, 1'b0);
      chk1("seq_bubble_vld", if_valid_o, 1'b0);
      chk32("seq_bubble_instr", if_instr_o, NOP);
      step(1'b0, 1'b0, 1'b0, 32'h0);
      chk1("seq_vld", if_valid_o, 1'b1);
      chk32("seq_pc", if_pc_o, 32'(4 * k));
      chk32("seq_instr", if_instr_o, 32'(4 * k));
      chk1("seq_next_req", imem_req, 1'b1);
      chk32("seq_next_addr", imem_addr, 32'(4 * k + 4));
    end

    // Stall across the response for PC 8
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b1, 1'b0, 32'h0);
      chk32("stall_pc", if_pc_o, 32'h4);
      chk1("stall_vld", if_valid_o, 1'b1);
      chk1("stall_noreq", imem_req, 1'b0);
    end
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk32("unstall_pc", if_pc_o, 32'h8);
    chk32("unstall_instr", if_instr_o, 32'h8);
    chk1("unstall_vld", if_valid_o, 1'b1);
    chk32("unstall_addr", imem_addr, 32'hC);

    // Redirect while waiting on a latency-3 response
    lat_min = 3; lat_max = 3;
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b1, 32'h103);
    chk1("redir_vld", if_valid_o, 1'b0);
    chk32("redir_instr", if_instr_o, NOP);
    chk32("redir_pc", if_pc_o, 32'h0);
    chk1("redir_noreq", imem_req, 1'b0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk1("drain_noreq", imem_req, 1'b0);
    chk1("drain_vld", if_valid_o, 1'b0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk1("redir_req", imem_req, 1'b1);
    chk32("redir_addr", imem_addr, 32'h100);
    chk1("redir_discard_vld", if_valid_o, 1'b0);

    // Redirect together with stall flushes a valid IF/ID slot
    lat_min = 1; lat_max = 1;
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk1("rs_pre_vld", if_valid_o, 1'b1);
    chk32("rs_pre_pc", if_pc_o, 32'h100);
    step(1'b0, 1'b1, 1'b1, 32'h200);
    chk1("rs_flush_vld", if_valid_o, 1'b0);
    chk32("rs_flush_instr", if_instr_o, NOP);
    chk32("rs_flush_pc", if_pc_o, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk1("rs_req", imem_req, 1'b1);
    chk32("rs_addr", imem_addr, 32'h200);

    // Reset with a request outstanding
    lat_min = 3; lat_max = 3;
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk1("rst_wait_req", imem_req, 1'b1);
    chk32("rst_wait_addr", imem_addr, 32'h0);
    chk1("rst_wait_vld", if_valid_o, 1'b0);
    chk32("rst_wait_instr", if_instr_o, NOP);

    lat_min = 1; lat_max = 4;
    for (int i = 0; i < 4000; i++) begin
      mem_salt = $urandom;
      step($urandom_range(99) == 0, $urandom_range(3) == 0,
           $urandom_range(11) == 0, $urandom);
    end

    chk1("wrap_done", wrap_done, 1'b1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // RESET_PC at the top of the address space: pc+4 wraps to zero
  initial begin
    w_rst = 1'b1; w_valid = 1'b0; w_rdata = 32'h0;
    @(negedge clk);
    w_rst = 1'b0;
    chk1("wrap_req0", w_req, 1'b1);
    chk32("wrap_addr0", w_addr, 32'hFFFF_FFFC);
    @(negedge clk);
    chk1("wrap_wait_noreq", w_req, 1'b0);
    w_valid = 1'b1;
    w_rdata = 32'h0BAD_C0DE;
    @(negedge clk);
    w_valid = 1'b0;
    chk1("wrap_vld", w_ivld, 1'b1);
    chk32("wrap_pc", w_pc, 32'hFFFF_FFFC);
    chk32("wrap_instr", w_instr, 32'h0BAD_C0DE);
    chk1("wrap_req1", w_req, 1'b1);
    chk32("wrap_addr1", w_addr, 32'h0000_0000);
    wrap_done = 1'b1;
  end

endmodule
